slope_divider: RTL and testbench
================================

Name: slope_divider

Overview:
- Sequential unsigned integer divider that computes the line slope m = dy/dx for the vertex rasteriser.
- Sits between vertex-difference logic and the point-store memory.
- Uses a start/done handshake and an iterative restoring algorithm, one quotient bit per clock.
- Also produces the remainder and a divide-by-zero flag.

Parameters:
- W, 4, operand/result width in bits (W >= 2).

Ports:
- c  input  1  clock, all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled only when busy=0.
- dividend  input  W  numerator (dy), unsigned.
- divisor  input  W  denominator (dx), unsigned.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  W  result m = floor(dividend/divisor).
- remainder  output  W  dividend mod divisor.
- div_by_zero  output  1  set with done when divisor was 0; held with the results.

Behaviour:
- Reset (async assert, released synchronously to c) sets:
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal counter and working registers cleared.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 with divisor!=0:
    - Latch the operands.
    - Clear the partial remainder.
    - Set count=W and busy=1.
    - Go to RUN.
  - start=1 with divisor=0:
    - Go to FINISH with quotient={W{1}}, remainder=dividend, div_by_zero=1.
    - busy=1 for that single cycle.
- RUN, each cycle (restoring step, MSB first):
  - Shift the partial remainder left, bringing in the next dividend bit.
  - If partial >= divisor: subtract divisor and set the quotient bit to 1; otherwise set it to 0.
  - Decrement count.
  - After W steps, go to FINISH.
- FINISH:
  - Load quotient, remainder and div_by_zero onto the outputs.
  - done=1 for exactly this cycle; busy=0.
  - Return to IDLE.
- Latency:
  - Normal: start sampled at edge N gives done=1 after edge N+W+1 (W+1 cycles).
  - Divide by zero: 1 cycle.
- Output hold:
  - Outputs hold the last result until the next FINISH.
  - div_by_zero clears at the next FINISH of a nonzero-divisor division.
- start while busy=1 (RUN or FINISH) is ignored; operands are not re-latched.
- Operand changes after acceptance have no effect on the running division.
- Back-to-back: start may be asserted in the cycle after done; the new division is accepted in IDLE.
- Arithmetic:
  - Purely unsigned.
  - Partial remainder held in W+1 bits internally, so no overflow.
  - Output remainder is < divisor.
- Edge values: dividend=0 gives q=0, r=0; divisor=1 gives q=dividend, r=0.
- rst mid-operation aborts the division immediately: all outputs return to reset values and no done pulse is produced.

Decomposition:
- Shared package:
  - Width constant W_COORD=4.
  - State enum {IDLE, RUN, FINISH}.
  - Coordinate typedef (logic [W_COORD-1:0]).
- Single module with no sub-modules; the per-step compare/subtract is inline combinational logic.
- globalMem (point store) is a separate block consuming quotient; it is not part of this module.

Test Plan:
- rst pulse mid-idle, then dividend=7, divisor=2, start -> done 5 cycles later (W=4); quotient=3, remainder=1, div_by_zero=0; busy high for the 4 RUN cycles plus FINISH.
- dividend=15, divisor=1 -> quotient=15, remainder=0; dividend=3, divisor=5 -> quotient=0, remainder=3; dividend=0, divisor=7 -> 0/0.
- dividend=9, divisor=0 -> done after 1 cycle; quotient=15, remainder=9, div_by_zero=1; next 8/4 -> quotient=2, remainder=0, div_by_zero=0.
- Start 14/3; 2 cycles later start again with 6/6 and change operands -> only one done; quotient=4, remainder=2.
- Start 13/4, assert rst after 2 RUN cycles -> outputs 0, busy=0, no done; after release, 13/4 -> quotient=3, remainder=1.
- Exhaustive sweep: all 256 operand pairs issued back-to-back -> each result matches floor division and mod, with the divisor=0 rule applied.

Source files
------------

// File: rtl/slope_divider_pkg.sv
// Shared definitions for the slope divider: the coordinate width, the
// controller state encoding and the coordinate type.
package slope_divider_pkg;

    // Width of one rasteriser coordinate difference (dy or dx)
    localparam int W_COORD = 4;

    // Divider controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // One coordinate-wide value
    typedef logic [W_COORD-1:0] coord_t;

endpackage

// File: rtl/slope_divider_if.sv
// Start/done handshake and operand/result bundle between the vertex-difference
// logic (master) and the slope divider (slave).
interface slope_divider_if
    import slope_divider_pkg::*;
#(
    parameter int W = W_COORD
) ();

    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    // Requester side: issues operands and start, observes results
    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    // Divider side: consumes operands, produces results
    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );

endinterface

// File: rtl/slope_divider.sv
// Sequential unsigned restoring divider producing the line slope dy/dx.
// One quotient bit per clock, MSB first. A zero divisor bypasses the
// iteration and reports all-ones quotient, remainder = dividend and a flag.
module slope_divider
    import slope_divider_pkg::*;
#(
    parameter int W = W_COORD
) (
    input  logic            c,
    input  logic            rst,
    slope_divider_if.slave  bus
);

    localparam int CW = $clog2(W + 1);

    state_t        state;
    logic [CW-1:0] count;
    // Partial remainder; one extra bit so the shifted value never overflows
    logic [W:0]    part;
    // Holds the dividend bits still to be consumed at the top and collects
    // quotient bits at the bottom; after W steps it holds the quotient
    logic [W-1:0]  dvd;
    logic [W-1:0]  dsr;
    logic          dbz;

    logic          step_bit;
    logic [W:0]    step_part;

    // One restoring step: shift in the next dividend bit, subtract the
    // divisor if it fits. Returns {quotient_bit, new_partial_remainder}.
    function automatic logic [W+1:0] restoring_step(
        input logic [W:0]   part_in,
        input logic         bit_in,
        input logic [W-1:0] dsr_in
    );
        logic [W:0] low;
        logic       ge;
        low = {part_in[W-1:0], bit_in};
        ge  = ({part_in, bit_in} >= {2'b00, dsr_in});
        if (ge) begin
            restoring_step = {1'b1, low - {1'b0, dsr_in}};
        end else begin
            restoring_step = {1'b0, low};
        end
    endfunction

    // Combinational compare/subtract for the current iteration
    always_comb begin
        {step_bit, step_part} = restoring_step(part, dvd[W-1], dsr);
    end

    // Controller and datapath: accept, iterate, publish results
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            part            <= '0;
            dvd             <= '0;
            dsr             <= '0;
            dbz             <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        dsr      <= bus.divisor;
                        if (bus.divisor != '0) begin
                            dvd   <= bus.dividend;
                            part  <= '0;
                            count <= CW'(W);
                            dbz   <= 1'b0;
                            state <= RUN;
                        end else begin
                            // No iteration: results are known immediately
                            dvd   <= '1;
                            part  <= {1'b0, bus.dividend};
                            count <= '0;
                            dbz   <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                RUN: begin
                    part  <= step_part;
                    dvd   <= {dvd[W-2:0], step_bit};
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bus.quotient    <= dvd;
                    bus.remainder   <= part[W-1:0];
                    bus.div_by_zero <= dbz;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slope_divider.sv
// Self-checking bench for slope_divider: directed handshake/abort cases,
// random operand pairs and a back-to-back sweep of every operand pair.
module tb_slope_divider;
    import slope_divider_pkg::*;

    localparam int W = W_COORD;

    logic c = 1'b0;
    logic rst;

    slope_divider_if #(.W(W)) bus ();

    slope_divider #(.W(W)) dut (
        .c   (c),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 c = ~c;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with the zero-divisor rule
    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << W) - 1;
            r = a;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    // Issue one division (inputs driven 1 time unit after an edge) and check
    // handshake timing, busy duration and results
    task automatic run_div(input int a, input int b, input string tag);
        int  q, r, z, lat, busy_cycles, exp_lat;
        bit  seen;
        ref_div(a, b, q, r, z);
        exp_lat = (b == 0) ? 1 : W + 1;
        bus.dividend = W'(a);
        bus.divisor  = W'(b);
        bus.start    = 1'b1;
        @(posedge c); #1;
        bus.start = 1'b0;
        chk({tag, ":busy_on_accept"}, 32'(bus.busy), 32'd1);
        chk({tag, ":done_low_on_accept"}, 32'(bus.done), 32'd0);
        busy_cycles = bus.busy ? 1 : 0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 3 * W + 4) begin
            @(posedge c); #1;
            lat++;
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_cycles++;
        end
        chk({tag, ":done_seen"}, 32'(seen), 32'd1);
        chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ":busy_cycles"}, 32'(busy_cycles), 32'(exp_lat));
        chk({tag, ":busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({tag, ":quotient"}, 32'(bus.quotient), 32'(q));
        chk({tag, ":remainder"}, 32'(bus.remainder), 32'(r));
        chk({tag, ":div_by_zero"}, 32'(bus.div_by_zero), 32'(z));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ":busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ":done"}, 32'(bus.done), 32'd0);
        chk({tag, ":quotient"}, 32'(bus.quotient), 32'd0);
        chk({tag, ":remainder"}, 32'(bus.remainder), 32'd0);
        chk({tag, ":div_by_zero"}, 32'(bus.div_by_zero), 32'd0);
    endtask

    // Hard watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dones, got_q, got_r, got_z;

        // Power-on reset
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge c);
        #1;
        chk_reset_state("por");
        @(negedge c);
        rst = 1'b0;
        @(posedge c); #1;

        // Leave a nonzero result, then pulse reset while idle
        run_div(11, 2, "pre_idle_rst");
        @(posedge c); #3;
        rst = 1'b1;
        #1;
        chk_reset_state("idle_rst");
        @(negedge c);
        rst = 1'b0;
        @(posedge c); #1;

        // Directed cases
        run_div(7, 2, "d7_2");
        run_div(15, 1, "d15_1");
        run_div(3, 5, "d3_5");
        run_div(0, 7, "d0_7");
        run_div(9, 0, "d9_0");
        // Results and flag hold while idle
        repeat (3) @(posedge c);
        #1;
        chk("hold:quotient", 32'(bus.quotient), 32'd15);
        chk("hold:remainder", 32'(bus.remainder), 32'd9);
        chk("hold:div_by_zero", 32'(bus.div_by_zero), 32'd1);
        run_div(8, 4, "d8_4");

        // start while busy is ignored; operand changes do not disturb the run
        bus.dividend = 4'd14;
        bus.divisor  = 4'd3;
        bus.start    = 1'b1;
        @(posedge c); #1;
        bus.start = 1'b0;
        @(posedge c); #1;
        bus.dividend = 4'd6;
        bus.divisor  = 4'd6;
        bus.start    = 1'b1;
        @(posedge c); #1;
        bus.start    = 1'b0;
        bus.dividend = 4'd1;
        bus.divisor  = 4'd1;
        dones = 0;
        got_q = 0;
        got_r = 0;
        got_z = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.done) begin
                dones++;
                got_q = int'(bus.quotient);
                got_r = int'(bus.remainder);
                got_z = int'(bus.div_by_zero);
            end
            @(posedge c); #1;
        end
        chk("ignore:done_count", 32'(dones), 32'd1);
        chk("ignore:quotient", 32'(got_q), 32'd4);
        chk("ignore:remainder", 32'(got_r), 32'd2);
        chk("ignore:div_by_zero", 32'(got_z), 32'd0);

        // Abort mid-run: reset after two RUN cycles
        bus.dividend = 4'd13;
        bus.divisor  = 4'd4;
        bus.start    = 1'b1;
        @(posedge c); #1;
        bus.start = 1'b0;
        @(posedge c);
        @(posedge c); #2;
        rst = 1'b1;
        #1;
        chk_reset_state("abort");
        @(negedge c);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 3 * W; i++) begin
            @(posedge c); #1;
            if (bus.done) dones++;
        end
        chk("abort:no_done", 32'(dones), 32'd0);
        chk("abort:busy_after", 32'(bus.busy), 32'd0);
        run_div(13, 4, "d13_4_after_abort");

        // Random operand pairs
        for (int i = 0; i < 40; i++) begin
            run_div(int'($urandom_range(0, (1 << W) - 1)),
                    int'($urandom_range(0, (1 << W) - 1)), "rand");
        end

        // Back-to-back exhaustive sweep
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                run_div(a, b, "sweep");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
